// File: rtl/mem_stream_reader_if.sv
// Bundles the burst request, the RAM read port and the output stream into one interface.
// master is the reader's view; slave is the view of the requester, RAM and stream sink.
// Widths follow WIDTH/DEPTH so that the reader and its environment agree on AW.
interface mem_stream_reader_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    // burst request
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [AW:0]      length;
    logic             busy;
    logic             done;

    // single-port RAM read path
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_rdata;

    // output stream
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        input  start,
        input  base_addr,
        input  length,
        input  mem_rdata,
        input  out_ready,
        output mem_addr,
        output out_valid,
        output out_data,
        output out_last,
        output busy,
        output done
    );

    modport slave (
        output start,
        output base_addr,
        output length,
        output mem_rdata,
        output out_ready,
        input  mem_addr,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  busy,
        input  done
    );
endinterface

// File: rtl/mem_stream_reader.sv
// Purpose: reads a burst of consecutive RAM words (address wraps at DEPTH) and streams them out.
// Latency: start sampled at edge E0 -> first out_valid after E2, then one word per cycle.
// Backpressure: out_ready low holds the head word; reads stop once in-flight + buffered words reach 4.
module mem_stream_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic                clk,
    input  logic                rst,
    mem_stream_reader_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [3:0]    SLOT_MAX  = 4'd4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_nxt;

    // burst bookkeeping
    logic [AW-1:0] addr_q;
    logic [AW:0]   len_q;
    logic [AW:0]   issued_q;
    logic [AW:0]   popped_q;
    logic          addr_vld_q;  // mem_addr carries a read this cycle
    logic          rd_vld_q;    // mem_rdata carries the word of last cycle's read
    logic          done_q;

    // 4-entry skid FIFO
    logic [WIDTH-1:0] fifo_mem [4];
    logic [1:0]       wr_ptr_q;
    logic [1:0]       rd_ptr_q;
    logic [2:0]       count_q;

    // FSM decisions
    logic accept;
    logic zero_len;
    logic issue;
    logic finish;

    logic       push;
    logic       pop;
    logic       fifo_vld;
    logic       head_is_last;
    logic [3:0] slots_used;

    assign fifo_vld     = (count_q != 3'd0);
    assign push         = rd_vld_q;
    assign pop          = fifo_vld && bus.out_ready;
    assign head_is_last = (popped_q == (len_q - CNT_ONE));
    // every read that has been issued but not yet popped owns a FIFO slot
    assign slots_used   = {1'b0, count_q} + {3'b000, addr_vld_q} + {3'b000, rd_vld_q};

    assign bus.out_valid = fifo_vld;
    assign bus.out_data  = fifo_mem[rd_ptr_q];
    assign bus.out_last  = fifo_vld && head_is_last;
    assign bus.mem_addr  = addr_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state plus the per-cycle accept/issue/finish decisions
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        zero_len  = 1'b0;
        issue     = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length != '0) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        zero_len = 1'b1;
                    end
                end
            end
            RUN: begin
                // start is deliberately not looked at here
                issue = (issued_q < len_q) && (slots_used < SLOT_MAX);
                if (pop && head_is_last) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address generation, read pipeline tracking, word counters and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            addr_vld_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q   <= zero_len || finish;
            rd_vld_q <= addr_vld_q;
            if (accept) begin
                // the first read is presented right away at base_addr
                addr_q     <= bus.base_addr;
                len_q      <= bus.length;
                issued_q   <= CNT_ONE;
                popped_q   <= '0;
                addr_vld_q <= 1'b1;
            end else begin
                addr_vld_q <= issue;
                if (issue) begin
                    addr_q   <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
                    issued_q <= issued_q + CNT_ONE;
                end
                if (pop) begin
                    popped_q <= popped_q + CNT_ONE;
                end
            end
        end
    end

    // FIFO storage: capture read data the cycle after its address, release on transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= bus.mem_rdata;
                wr_ptr_q           <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + {2'b00, push} - {2'b00, pop};
        end
    end
endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: RAM holds mem[i]=i+1, bursts are checked word by word.
// Inputs change and outputs are sampled on the falling clock edge.
// Covers reset, basic, wrap, back-to-back, backpressure, zero length, full length, stray start, mid-burst reset.
module tb_mem_stream_reader;
    logic clk;
    logic rst;

    int n_assert = 0;
    int n_fail   = 0;
    int max_occ  = 0;

    logic [7:0] ram [256];

    mem_stream_reader_if #(.WIDTH(8), .DEPTH(256)) bus ();

    mem_stream_reader #(.WIDTH(8), .DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous-read RAM: data valid the cycle after the address
    always @(posedge clk) bus.mem_rdata <= ram[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one burst starting at the current falling edge; returns at the falling edge of the done cycle.
    // mode 0: ready always high; 1: random ready with a 10-cycle low window; 2: stray start mid-burst.
    task automatic burst(input logic [7:0] base, input logic [8:0] len, input int mode, input string tag);
        int         k;
        int         cyc;
        bit         fin;
        bit         prev_stall;
        logic [7:0] prev_d;
        logic       prev_l;
        logic [7:0] exp_d;
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.length    = len;
        bus.out_ready = (mode != 1);
        @(negedge clk);
        bus.start = 1'b0;
        chk($sformatf("%s_busy_rise", tag), bus.busy, 1);
        chk($sformatf("%s_first_addr", tag), bus.mem_addr, base);
        k          = 0;
        cyc        = 1;
        fin        = 1'b0;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        while (!fin && cyc < 3000) begin
            bus.start = (mode == 2 && cyc == 5);
            if (mode == 2 && cyc == 5) begin
                bus.base_addr = base + 8'h40;
                bus.length    = 9'd3;
            end
            if (mode == 1) begin
                bus.out_ready = (cyc >= 6 && cyc < 16) ? 1'b0 : 1'($urandom_range(0, 1));
            end
            if (dut.count_q > max_occ) max_occ = dut.count_q;
            if (prev_stall) begin
                chk($sformatf("%s_valid_hold", tag), bus.out_valid, 1);
                chk($sformatf("%s_data_hold", tag), bus.out_data, prev_d);
                chk($sformatf("%s_last_hold", tag), bus.out_last, prev_l);
            end
            if (bus.out_valid) begin
                exp_d = ram[8'(base + k)];
                if (k == 0) chk($sformatf("%s_first_valid_cycle", tag), cyc, 3);
                chk($sformatf("%s_data_%0d", tag, k), bus.out_data, exp_d);
                chk($sformatf("%s_last_%0d", tag, k), bus.out_last, (k == int'(len) - 1));
                if (bus.out_ready) begin
                    if (k == int'(len) - 1) begin
                        fin = 1'b1;
                        if (mode != 1) chk($sformatf("%s_last_cycle", tag), cyc, int'(len) + 2);
                    end
                    k++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_d     = bus.out_data;
                    prev_l     = bus.out_last;
                end
            end else begin
                prev_stall = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk($sformatf("%s_word_count", tag), k, len);
        chk($sformatf("%s_done", tag), bus.done, 1);
        chk($sformatf("%s_busy_fall", tag), bus.busy, 0);
        chk($sformatf("%s_valid_after", tag), bus.out_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i + 1);
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_addr", bus.mem_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // base 0x10, 4 words: 0x11..0x14, then the done pulse lasts one cycle
        burst(8'h10, 9'd4, 0, "basic");
        @(negedge clk);
        chk("basic_done_drop", bus.done, 0);

        // wrap across the top of the RAM, then back-to-back start in the done cycle
        burst(8'hFE, 9'd4, 0, "wrap");
        burst(8'h50, 9'd2, 0, "b2b");
        @(negedge clk);
        chk("b2b_done_drop", bus.done, 0);

        // backpressure with random ready and a long stall
        max_occ = 0;
        burst(8'h80, 9'd8, 1, "bp");
        chk("bp_occupancy_le4", (max_occ <= 4), 1);
        @(negedge clk);

        // zero length: no reads, done on the next cycle only
        bus.start     = 1'b1;
        bus.base_addr = 8'h33;
        bus.length    = 9'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("zero_done", bus.done, 1);
        chk("zero_busy", bus.busy, 0);
        chk("zero_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("zero_done_drop", bus.done, 0);
        repeat (3) @(negedge clk);
        chk("zero_valid_late", bus.out_valid, 0);
        chk("zero_busy_late", bus.busy, 0);

        // full-depth burst from address 0
        burst(8'h00, 9'd256, 0, "full");
        @(negedge clk);

        // start pulsed while busy is ignored
        burst(8'h60, 9'd6, 2, "midstart");
        @(negedge clk);
        chk("midstart_no_rerun", bus.busy, 0);

        // reset in the middle of a stalled burst
        bus.start     = 1'b1;
        bus.base_addr = 8'h20;
        bus.length    = 9'd8;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mrst_valid_before", bus.out_valid, 1);
        chk("mrst_data_before", bus.out_data, 8'h21);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_data", bus.out_data, 0);
        chk("mrst_last", bus.out_last, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_done", bus.done, 0);
        chk("mrst_addr", bus.mem_addr, 0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_no_done", bus.done, 0);
        chk("mrst_valid_late", bus.out_valid, 0);
        burst(8'h30, 9'd3, 0, "post_rst");
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, words in attached RAM; AW = $clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  AW  first RAM address of the burst.
REQ-007 SHALL have port length  input  AW+1  words to read, 0..DEPTH.
REQ-008 SHALL have port mem_addr  output  AW  registered address to the single-port RAM.
REQ-009 SHALL have port mem_rdata  input  WIDTH  RAM read data, valid one cycle after the address.
REQ-010 SHALL have port out_valid  output  1  stream word available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts word.
REQ-012 SHALL have port out_data  output  WIDTH  stream word.
REQ-013 SHALL have port out_last  output  1  marks the final word of the burst.
REQ-014 SHALL have port busy  output  1  burst in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at burst completion.

Function
REQ-016 SHALL implement FSM states IDLE and RUN.
REQ-017 In IDLE with start=1 and length>0: capture base_addr/length, go to RUN, busy=1 next cycle, mem_addr=base_addr next cycle.
REQ-018 In IDLE with start=1 and length=0: stay IDLE, no reads, done=1 for exactly the next cycle.
REQ-019 start while busy=1 SHALL be ignored with no effect on the burst in progress.
REQ-020 Read issue: one word per cycle while issued<length and (reads in flight + FIFO occupancy) < 4.
REQ-021 Each issue SHALL advance mem_addr by 1 modulo DEPTH (DEPTH-1 wraps to 0).
REQ-022 mem_rdata SHALL be captured into a 4-entry FIFO on the cycle after its address was presented; FIFO SHALL never overflow.
REQ-023 out_valid = FIFO non-empty; a word transfers when out_valid & out_ready at posedge clk.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-025 out_last=1 exactly on the word number length (1-based) and only while that word is at FIFO head.
REQ-026 Latency: start sampled at edge E0 gives first out_valid=1 after edge E2.
REQ-027 Throughput: with out_ready held 1, one word per cycle with no bubbles after the first.
REQ-028 On transfer of the out_last word: return to IDLE, busy=0 and done=1 for one cycle after that edge.
REQ-029 Words SHALL appear in address order with no loss or duplication under any out_ready pattern.
REQ-030 start may be accepted in the cycle in which done=1, giving back-to-back bursts.

Reset
REQ-031 rst=1 at a posedge SHALL force state IDLE, empty FIFO, zero in-flight count, mem_addr=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
REQ-032 rst SHALL take priority over start and over any transfer in the same cycle; a burst interrupted by rst is abandoned, with no done pulse.

Verification
REQ-033 RAM mem[i]=i+1; base=0x10, length=4, out_ready=1 -> out_data 0x11,0x12,0x13,0x14 on consecutive cycles, first after E2, out_last on 0x14, then done pulse.
REQ-034 Wrap: base=0xFE, length=4 -> data from addresses 0xFE,0xFF,0x00,0x01 = 0xFF,0x00,0x01,0x02.
REQ-035 Backpressure: length=8, out_ready randomly toggled (incl. low 10 cycles) -> exactly 8 words in order, data stable while stalled, FIFO occupancy never >4.
REQ-036 length=0 -> no out_valid, busy stays 0, done pulse the next cycle; length=256 from base=0 -> 256 words, out_last only on the 256th.
REQ-037 start pulsed mid-burst -> ignored; rst asserted mid-burst -> all outputs 0 next cycle, no done; a new burst after rst completes correctly.
REQ-038 Back-to-back: start asserted in the done cycle with length=2 -> second burst streams correctly with no stale words.
